// File: rtl/rob_retire_queue_pkg.sv
// rob_retire_queue_pkg
//   Shared types for the in-order retirement queue and its neighbours:
//   register index width (REG_ADDR_LEN), default ROB depth, the renamer's
//   per-instruction physical-register record (phys_reg_t) and the stored
//   reorder-buffer entry layout (rob_entry_t).
package rob_retire_queue_pkg;

  localparam int unsigned REG_ADDR_LEN      = 5;
  localparam int unsigned REG_W             = REG_ADDR_LEN;
  localparam int unsigned ROB_DEPTH_DEFAULT = 8;

  typedef logic [REG_W-1:0] arch_reg_t;

  // Renamer output for one instruction: newly allocated destination and the
  // mapping it displaced (freed once the instruction retires).
  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] dest_old;
  } phys_reg_t;

  typedef struct packed {
    logic             valid;
    logic             done;
    arch_reg_t        arch_dest;
    logic [REG_W-1:0] phys_dest;
    logic [REG_W-1:0] phys_dest_old;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_queue_if.sv
// rob_retire_queue_if
//   Dispatch / completion / commit bundle of the retirement queue.
//   slave  : the queue (takes dispatch and completion, drives commit/status)
//   master : the surrounding pipeline (renamer, CDB, commit consumers)
//   Signals:
//     dispatch_valid, dispatch_arch_dest, dispatch_phys  -> queue
//     dispatch_ready, dispatch_rob_idx                   <- queue
//     complete_valid, complete_rob_idx                   -> queue
//     commit_flag, commit_phys_reg, commit_phys_dest,
//     commit_arch_dest, rob_count                        <- queue
interface rob_retire_queue_if
  import rob_retire_queue_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT
);
  localparam int unsigned IDX_W = $clog2(ROB_DEPTH);

  logic             dispatch_valid;
  arch_reg_t        dispatch_arch_dest;
  phys_reg_t        dispatch_phys;
  logic             dispatch_ready;
  logic [IDX_W-1:0] dispatch_rob_idx;
  logic             complete_valid;
  logic [IDX_W-1:0] complete_rob_idx;
  logic             commit_flag;
  logic [REG_W-1:0] commit_phys_reg;
  logic [REG_W-1:0] commit_phys_dest;
  arch_reg_t        commit_arch_dest;
  logic [IDX_W:0]   rob_count;

  modport slave (
    input  dispatch_valid, dispatch_arch_dest, dispatch_phys,
    input  complete_valid, complete_rob_idx,
    output dispatch_ready, dispatch_rob_idx,
    output commit_flag, commit_phys_reg, commit_phys_dest, commit_arch_dest,
    output rob_count
  );

  modport master (
    output dispatch_valid, dispatch_arch_dest, dispatch_phys,
    output complete_valid, complete_rob_idx,
    input  dispatch_ready, dispatch_rob_idx,
    input  commit_flag, commit_phys_reg, commit_phys_dest, commit_arch_dest,
    input  rob_count
  );

endinterface

// File: rtl/rob_retire_queue_circ_ptr.sv
// rob_circ_ptr
//   Wrapping W-bit pointer (modulo 2**W) with increment enable, synchronous
//   clear and asynchronous active-high reset. Used for ROB head and tail.
//   Ports: clk, reset (async), clr (sync clear, wins over en), en, ptr.
module rob_circ_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_retire_queue.sv
// rob_retire_queue
//   In-order retirement queue (reorder-buffer core). Instructions are written
//   at tail on dispatch, marked done by ROB index on completion, and the oldest
//   entry retires once done, returning its displaced mapping (dest_old) to the
//   renamer's free list through commit_phys_reg.
//   Ports:
//     clk, reset        clock, asynchronous active-high reset
//     flush             (only with ROB_FLUSH_EN) drop all in-flight entries
//     rq (slave)        dispatch / completion / commit bundle
//   Optional feature macro: ROB_FLUSH_EN adds the flush input.
module rob_retire_queue
  import rob_retire_queue_pkg::*;
#(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  rob_retire_queue_if.slave rq
);

  localparam int unsigned    IDX_W      = $clog2(ROB_DEPTH);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ROB_DEPTH);

  rob_entry_t       entries [ROB_DEPTH];
  rob_entry_t       head_entry;
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic             flush_now;
  logic             ready;
  logic             do_dispatch;
  logic             do_retire;

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // Ready comes from the registered count only, so a full queue stays
  // not-ready through a retire cycle.
  assign ready       = (count != FULL_COUNT);
  assign head_entry  = entries[head];
  assign do_dispatch = rq.dispatch_valid && ready;
  assign do_retire   = head_entry.valid && head_entry.done;

  assign rq.dispatch_ready   = ready;
  assign rq.dispatch_rob_idx = tail;
  assign rq.rob_count        = count;

  rob_circ_ptr #(.W(IDX_W)) u_head_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush_now),
    .en    (do_retire),
    .ptr   (head)
  );

  rob_circ_ptr #(.W(IDX_W)) u_tail_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush_now),
    .en    (do_dispatch),
    .ptr   (tail)
  );

  // Completion is applied before the retire clear so a completion hitting the
  // retiring head cannot resurrect it; the slot at tail is never valid while
  // a dispatch is accepted, so completions aimed at it are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (flush_now) begin
      for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (rq.complete_valid && entries[rq.complete_rob_idx].valid) begin
        entries[rq.complete_rob_idx].done <= 1'b1;
      end
      if (do_retire) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
      end
      if (do_dispatch) begin
        entries[tail].valid         <= 1'b1;
        entries[tail].done          <= 1'b0;
        entries[tail].arch_dest     <= rq.dispatch_arch_dest;
        entries[tail].phys_dest     <= rq.dispatch_phys.dest;
        entries[tail].phys_dest_old <= rq.dispatch_phys.dest_old;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (flush_now) begin
      count <= '0;
    end else begin
      case ({do_dispatch, do_retire})
        2'b10:   count <= count + (IDX_W+1)'(1);
        2'b01:   count <= count - (IDX_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // commit_* hold the last retired entry between retirements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq.commit_flag      <= 1'b0;
      rq.commit_phys_reg  <= '0;
      rq.commit_phys_dest <= '0;
      rq.commit_arch_dest <= '0;
    end else if (flush_now) begin
      rq.commit_flag <= 1'b0;
    end else if (do_retire) begin
      rq.commit_flag      <= 1'b1;
      rq.commit_phys_reg  <= head_entry.phys_dest_old;
      rq.commit_phys_dest <= head_entry.phys_dest;
      rq.commit_arch_dest <= head_entry.arch_dest;
    end else begin
      rq.commit_flag <= 1'b0;
    end
  end

endmodule

// File: doc/rob_retire_queue.md
Name: rob_retire_queue

Overview:
In-order retirement queue (reorder buffer core) for the P6-style Tomasulo pipeline. It consumes the renamer's per-instruction output (dest, dest_old) at dispatch and tracks completion by ROB index. It retires the oldest completed instruction, driving commit_flag/commit_phys_reg back into RegisterRenaming so dest_old returns to the free list. It is the commit-side counterpart of the renaming block.

Parameters:
ROB_DEPTH, 8, number of entries; power of 2, min 2
IDX_W, $clog2(ROB_DEPTH), ROB index width (derived)
REG_W, `REG_ADDR_LEN (5), arch/phys register index width

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
dispatch_valid  input  1  new instruction offered
dispatch_arch_dest  input  REG_W  architectural destination
dispatch_phys  input  PHYS_REG  renamer output; only dest and dest_old stored
dispatch_ready  output  1  entry available (registered-count based)
dispatch_rob_idx  output  IDX_W  index the offered instruction receives (= tail)
complete_valid  input  1  execution finished (from CDB)
complete_rob_idx  input  IDX_W  ROB index of finished instruction
commit_flag  output  1  one instruction retired this cycle
commit_phys_reg  output  REG_W  physical reg to free (retired entry's dest_old)
commit_phys_dest  output  REG_W  retired entry's new dest (retirement RAT)
commit_arch_dest  output  REG_W  retired entry's arch dest
rob_count  output  IDX_W+1  occupied entries

Behaviour:
- State: entry array {valid, done, arch_dest, phys_dest, phys_dest_old}; head, tail (IDX_W, wrap mod ROB_DEPTH); count (IDX_W+1).
- Reset (async, immediate): head=tail=count=0; all valid/done=0; commit_flag=0; commit_* =0; dispatch_ready=1; dispatch_rob_idx=0; rob_count=0. Reset mid-operation discards all entries; no commit issued.
- Dispatch: accepted at posedge when dispatch_valid && dispatch_ready. Writes entry[tail] with valid=1, done=0. tail++.
- dispatch_ready = (count != ROB_DEPTH). There is no same-cycle bypass from a retire: when full, ready stays 0 even if a retire occurs that cycle.
- Completion: at posedge, if complete_valid and entry[complete_rob_idx].valid, set done=1.
  - Completion to an invalid entry is ignored, including the entry being dispatched the same cycle.
  - Repeat completion is harmless.
- Retire decision is combinational on registered state: retire = entry[head].valid && entry[head].done.
- When retire is true at posedge:
  - commit_flag<=1; commit_phys_reg<=dest_old; commit_phys_dest<=phys_dest; commit_arch_dest<=arch_dest.
  - Clear entry[head].valid/done; head++.
- Otherwise commit_flag<=0 and commit_* hold their previous values.
- Max one retire per cycle.
- Latency: completion sampled at edge E → commit_flag high in the cycle after edge E+1. Minimum dispatch-to-commit is 3 edges (dispatch, complete, retire).
- count: +1 on dispatch only, -1 on retire only, unchanged on both.
- Empty (count=0): no retire.
- Out-of-order completion: younger done entries wait until head is done, then retire one per cycle in order.
- arch_dest=0 entries retire normally; the renamer owns any x0 filtering.

Optional Feature:
ROB_FLUSH_EN
- With the macro: adds input flush (1 bit). At posedge with flush=1:
  - All valid/done are cleared; head=tail=count=0; commit_flag<=0.
  - Same-cycle dispatch, completion and retire are dropped.
  - Flush has priority over everything except reset.
- Without the macro: no flush port; state is cleared only by reset.

Decomposition:
- Shared header (alongside ARCH_REG/PHYS_REG): ROB_ENTRY struct typedef, `ROB_DEPTH default, reuse of `REG_ADDR_LEN.
- One natural sub-module: rob_circ_ptr (wrapping increment pointer with enable and async reset), instantiated for head and tail.

Test Plan:
1. Reset, then dispatch {arch_dest=1, dest=9, dest_old=1}; complete idx 0 next cycle → commit_flag=1 one cycle later with commit_phys_reg=1, commit_phys_dest=9, commit_arch_dest=1; rob_count returns to 0.
2. Dispatch idx 0,1,2 (dest_old 1,2,3); complete 2, then 1, then 0 → no commit until idx 0 is done; then commits dest_old 1,2,3 on three consecutive cycles.
3. Dispatch 8 entries → dispatch_ready=0, rob_count=8. Complete idx 0 with dispatch_valid held → ready stays 0 during the retire cycle, then rises. Next dispatch gets dispatch_rob_idx=0 (wrap).
4. At count=4, same cycle dispatch + retire → rob_count stays 4, tail and head each advance by 1.
5. complete_valid to empty idx 5 → no state change. Assert reset with 3 entries pending → all outputs 0 immediately, no commit afterwards.
6. (ROB_FLUSH_EN) 4 entries with idx 0 done, flush=1 → no commit, rob_count=0, next dispatch idx 0.
